// File: rtl/pulse_burst_scheduler_pkg.sv
// Shared types and default sizing for the pulse burst scheduler and its
// period tick generator.
package pulse_sched_pkg;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_BURST_W = 8;
    localparam int DEF_MIN_PER = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_burst_scheduler_if.sv
// Config, command and status bundle between control logic (master) and the
// pulse burst scheduler (slave).
interface pulse_burst_scheduler_if
    import pulse_sched_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
);
    logic [CNT_W-1:0]   cfg_period;
    logic [BURST_W-1:0] cfg_burst;
    logic               cmd_start;
    logic               cmd_stop;
    logic               start_ack;
    logic               busy;
    logic               pulse_out;
    logic [BURST_W-1:0] pulse_idx;
    logic               done;
    logic               aborted;

    modport master (
        output cfg_period, cfg_burst, cmd_start, cmd_stop,
        input  start_ack, busy, pulse_out, pulse_idx, done, aborted
    );

    modport slave (
        input  cfg_period, cfg_burst, cmd_start, cmd_stop,
        output start_ack, busy, pulse_out, pulse_idx, done, aborted
    );

endinterface

// File: rtl/pulse_burst_scheduler_tick_gen.sv
// Loadable modulo-period counter: tick is high for the one enabled cycle in
// which the counter sits at period-1, and the counter wraps on that edge.
module period_tick_gen
    import pulse_sched_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MIN_PER = DEF_MIN_PER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] period,
    input  logic             en,
    input  logic             clr,
    output logic             tick
);

    localparam logic [CNT_W-1:0] MIN_PER_C = CNT_W'(MIN_PER);

    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] per_clamped;

    // Periods below the minimum would make the tick continuous or undefined.
    assign per_clamped = (period < MIN_PER_C) ? MIN_PER_C : period;
    assign tick        = en && (count_q == (per_q - CNT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_q   <= MIN_PER_C;
            count_q <= '0;
        end else if (load) begin
            per_q   <= per_clamped;
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= tick ? '0 : (count_q + CNT_W'(1));
        end
    end

endmodule

// File: rtl/pulse_burst_scheduler.sv
// Burst scheduler: accepts a start command, issues a burst of periodic
// single-cycle pulses, then reports completion or abort.
module pulse_burst_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W,
    parameter int MIN_PER = DEF_MIN_PER
) (
    input logic                    clk,
    input logic                    rst_n,
    pulse_burst_scheduler_if.slave bus
);

    state_t state;
    state_t state_nxt;

    logic               accept;
    logic               tick;
    logic               tick_en;
    logic               tick_clr;
    logic               last_pulse;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] idx_q;
    logic [BURST_W-1:0] idx_inc;
    logic               abort_q;
    logic               start_ack_q;
    logic               busy_q;
    logic               pulse_q;
    logic               done_q;
    logic               aborted_q;

    // Stop suppresses the tick outright, so a pulse due on the stop edge never fires.
    assign tick_en    = (state == RUN) && !bus.cmd_stop;
    assign tick_clr   = (state == RUN) &&  bus.cmd_stop;
    assign idx_inc    = idx_q + BURST_W'(1);
    assign last_pulse = tick && (burst_q != '0) && (idx_inc == burst_q);

    period_tick_gen #(
        .CNT_W   (CNT_W),
        .MIN_PER (MIN_PER)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .period (bus.cfg_period),
        .en     (tick_en),
        .clr    (tick_clr),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.cmd_stop || last_pulse) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered; done trails the DONE state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q     <= '0;
            idx_q       <= '0;
            abort_q     <= 1'b0;
            start_ack_q <= 1'b0;
            busy_q      <= 1'b0;
            pulse_q     <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            start_ack_q <= accept;
            pulse_q     <= tick;
            done_q      <= (state == DONE);
            aborted_q   <= (state == DONE) && abort_q;
            busy_q      <= (state_nxt != IDLE) || (state == DONE);
            if (accept) begin
                burst_q <= bus.cfg_burst;
                idx_q   <= '0;
                abort_q <= 1'b0;
            end else if (tick) begin
                idx_q <= idx_inc;
            end
            if (tick_clr) abort_q <= 1'b1;
        end
    end

    assign bus.start_ack = start_ack_q;
    assign bus.busy      = busy_q;
    assign bus.pulse_out = pulse_q;
    assign bus.pulse_idx = idx_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Scoreboard bench for pulse_burst_scheduler: expected pulses and completions
// are queued at stimulus time and matched as the DUT produces them.
module tb_pulse_burst_scheduler;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int cyc;
        int idx;
    } pulse_exp_t;

    typedef struct {
        int   cyc;
        logic ab;
    } done_exp_t;

    pulse_exp_t pq[$];
    done_exp_t  dq[$];
    pulse_exp_t pe;
    done_exp_t  de;

    pulse_burst_scheduler_if #(.CNT_W(8), .BURST_W(8)) bus ();
    pulse_burst_scheduler_if #(.CNT_W(8), .BURST_W(4)) bus4 ();

    pulse_burst_scheduler #(.CNT_W(8), .BURST_W(8), .MIN_PER(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pulse_burst_scheduler #(.CNT_W(8), .BURST_W(4), .MIN_PER(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Matches every observed pulse and completion against the head of its queue.
    always @(negedge clk) begin
        if (bus.pulse_out === 1'b1) begin
            if (pq.size() == 0) checkOutput("unexpected pulse", 1, 0);
            else begin
                pe = pq.pop_front();
                checkOutput("pulse cycle", cyc, pe.cyc);
                checkOutput("pulse idx", 32'(bus.pulse_idx), pe.idx);
            end
        end
        if (bus.done === 1'b1) begin
            if (dq.size() == 0) checkOutput("unexpected done", 1, 0);
            else begin
                de = dq.pop_front();
                checkOutput("done cycle", cyc, de.cyc);
                checkOutput("done aborted", 32'(bus.aborted), 32'(de.ab));
            end
        end
    end

    task automatic waitUntilCycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((pq.size() + dq.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", pq.size() + dq.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Starts a burst and queues its expected pulses and completion.
    task automatic applyStimulus(input int per, input int burst, output int t);
        int eff;
        eff = (per < 2) ? 2 : per;
        @(negedge clk);
        bus.cfg_period = 8'(per);
        bus.cfg_burst  = 8'(burst);
        bus.cmd_start  = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        bus.cmd_start = 1'b0;
        if (burst != 0) begin
            for (int k = 1; k <= burst; k++) pq.push_back('{cyc: t + k * eff, idx: k});
            dq.push_back('{cyc: t + burst * eff + 1, ab: 1'b0});
        end
        @(negedge clk);
        checkOutput("start_ack", 32'(bus.start_ack), 1);
        checkOutput("busy after start", 32'(bus.busy), 1);
    endtask

    task automatic runScenario1;
        int t;
        applyStimulus(10, 3, t);
        waitUntilCycle(t + 1);
        checkOutput("start_ack one cycle", 32'(bus.start_ack), 0);
        waitUntilCycle(t + 31);
        checkOutput("busy with done", 32'(bus.busy), 1);
        waitUntilCycle(t + 32);
        checkOutput("busy after done", 32'(bus.busy), 0);
        checkOutput("final idx", 32'(bus.pulse_idx), 3);
        waitDrain(200);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int t;
        int c;
        rst_n = 1'b1;
        bus.cfg_period = '0;  bus.cfg_burst = '0;  bus.cmd_start = 1'b0;  bus.cmd_stop = 1'b0;
        bus4.cfg_period = '0; bus4.cfg_burst = '0; bus4.cmd_start = 1'b0; bus4.cmd_stop = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(bus.busy), 0);
        checkOutput("reset idx", 32'(bus.pulse_idx), 0);
        checkOutput("reset pulse", 32'(bus.pulse_out), 0);
        checkOutput("reset done", 32'(bus.done), 0);
        checkOutput("reset ack", 32'(bus.start_ack), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] basic burst per=10 burst=3");
        runScenario1();

        $display("[TB] period clamp");
        applyStimulus(0, 3, t);
        waitDrain(200);
        applyStimulus(1, 2, t);
        waitDrain(200);

        $display("[TB] stop on due pulse edge");
        applyStimulus(5, 0, t);
        for (int k = 1; k <= 3; k++) pq.push_back('{cyc: t + 5 * k, idx: k});
        dq.push_back('{cyc: t + 21, ab: 1'b1});
        waitUntilCycle(t + 19);
        bus.cmd_stop = 1'b1;
        @(posedge clk);
        #1 bus.cmd_stop = 1'b0;
        waitDrain(200);
        checkOutput("idx after stop", 32'(bus.pulse_idx), 3);
        checkOutput("busy after stop", 32'(bus.busy), 0);

        $display("[TB] start and cfg change during run");
        applyStimulus(10, 3, t);
        waitUntilCycle(t + 5);
        bus.cmd_start  = 1'b1;
        bus.cfg_period = 8'd3;
        bus.cfg_burst  = 8'd7;
        @(posedge clk);
        #1 bus.cmd_start = 1'b0;
        @(negedge clk);
        checkOutput("no ack in run", 32'(bus.start_ack), 0);
        waitDrain(200);

        $display("[TB] continuous wrap BURST_W=4");
        @(negedge clk);
        bus4.cfg_period = 8'd2;
        bus4.cfg_burst  = 4'd0;
        bus4.cmd_start  = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        bus4.cmd_start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            waitUntilCycle(t + 2 * k - 1);
            checkOutput("wrap gap", 32'(bus4.pulse_out), 0);
            waitUntilCycle(t + 2 * k);
            checkOutput("wrap pulse", 32'(bus4.pulse_out), 1);
            checkOutput("wrap idx", 32'(bus4.pulse_idx), k % 16);
        end
        c = cyc;
        bus4.cmd_stop = 1'b1;
        @(posedge clk);
        #1 bus4.cmd_stop = 1'b0;
        waitUntilCycle(c + 2);
        checkOutput("wrap done", 32'(bus4.done), 1);
        checkOutput("wrap aborted", 32'(bus4.aborted), 1);
        repeat (3) @(negedge clk);

        $display("[TB] async reset mid-burst");
        applyStimulus(10, 3, t);
        waitUntilCycle(t + 15);
        checkOutput("idx before reset", 32'(bus.pulse_idx), 1);
        #2 rst_n = 1'b0;
        pq.delete();
        dq.delete();
        #1;
        checkOutput("async busy", 32'(bus.busy), 0);
        checkOutput("async idx", 32'(bus.pulse_idx), 0);
        checkOutput("async pulse", 32'(bus.pulse_out), 0);
        checkOutput("async done", 32'(bus.done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        runScenario1();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
